pin_entry_collector: RTL and testbench

- Keypad-side writer for the 4-digit code register.
- Collects BCD digit keystrokes serially from the keypad decoder and assembles them into digit4..digit1, with digit4 being the first key pressed.
- Supports clear, backspace and enter keys, plus an inactivity timeout.
- On a valid enter, presents the four digits with a one-cycle load pulse that drives the code register's load input directly.

---
 rtl/pin_entry_pkg.sv | 24 ++
 rtl/pin_entry_collector_if.sv | 27 ++
 rtl/inactivity_timer.sv | 44 ++++
 rtl/pin_entry_collector.sv | 119 +++++++++++
 tb/tb_pin_entry_collector.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pin_entry_pkg.sv
// Shared definitions for the keypad PIN entry collector.
//   KEY_*       : special key codes delivered by the keypad decoder
//   NUM_DIGITS  : number of digits in a complete code
//   state_e     : collector FSM states
package pin_entry_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;
   localparam logic [3:0] KEY_BKSP  = 4'hC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no digits held
      ENTRY = 2'd1,   // 1..4 digits held
      DONE  = 2'd2    // single cycle presenting a complete code
   } state_e;

   // Decimal digit keys are 0-9; A-F are commands or ignored.
   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_entry_collector_if.sv
// Keypad-to-code-register bus for the PIN entry collector.
//   key_valid/key_code           : keystroke strobe from the keypad decoder
//   digit4..digit1, count        : assembled code and number of digits held
//   load, entry_error, timeout   : one-cycle event pulses
// The slave modport is the collector; the master modport is its environment.
interface pin_entry_collector_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] digit4;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [2:0] count;
   logic       load;
   logic       entry_error;
   logic       timeout;

   modport master (
      output key_valid, key_code,
      input  digit4, digit3, digit2, digit1, count, load, entry_error, timeout
   );

   modport slave (
      input  key_valid, key_code,
      output digit4, digit3, digit2, digit1, count, load, entry_error, timeout
   );
endinterface

// File: rtl/inactivity_timer.sv
// Inactivity counter for the PIN entry collector.
//   clk, reset : clock and asynchronous active-high reset
//   run        : count while high, otherwise held at 0
//   restart    : force the count back to 0 (takes priority over run)
//   expire     : high while running with the count at TIMEOUT-1
module inactivity_timer #(
   parameter int TIMEOUT = 50000000,
   parameter int TW      = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic restart,
   output logic expire
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (restart || !run) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         // The owner leaves the running state on expiry; wrap for safety.
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/pin_entry_collector.sv
// Keypad-side writer for the 4-digit code register.
//   clk, reset : clock and asynchronous active-high reset
//   kp (slave) : key_valid/key_code in; digit4..digit1, count, load,
//                entry_error, timeout out (all registered)
// Digits shift in from digit1 so digit4 ends up holding the first key.
// Enter with four digits produces a one-cycle DONE state with load=1,
// after which the entry clears. Partial entries are discarded after
// TIMEOUT idle cycles.
module pin_entry_collector
   import pin_entry_pkg::*;
#(
   parameter int TIMEOUT = 50000000,
   parameter int TW      = 26
) (
   input  logic                 clk,
   input  logic                 reset,
   pin_entry_collector_if.slave kp
);

   localparam logic [2:0] FULL = 3'(NUM_DIGITS);

   state_e     state_q, state_d;
   // digit_q[NUM_DIGITS-1] is digit4 (first key), digit_q[0] is digit1.
   logic [3:0] digit_q [NUM_DIGITS];
   logic [3:0] digit_d [NUM_DIGITS];
   logic [2:0] count_q, count_d;
   logic       load_q, load_d;
   logic       err_q, err_d;
   logic       to_q, to_d;
   logic       expire;

   inactivity_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .run     (state_q == ENTRY),
      .restart (kp.key_valid),
      .expire  (expire)
   );

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      count_d = count_q;
      load_d  = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;

      if (state_q == DONE) begin
         // Code has been presented; any key this cycle is dropped.
         state_d = IDLE;
         count_d = '0;
         for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = '0;
      end else if (kp.key_valid) begin
         if (is_digit(kp.key_code)) begin
            if (count_q < FULL) begin
               for (int i = NUM_DIGITS - 1; i > 0; i--) digit_d[i] = digit_q[i-1];
               digit_d[0] = kp.key_code;
               count_d    = count_q + 1'b1;
               state_d    = ENTRY;
            end
         end else if (kp.key_code == KEY_CLEAR) begin
            state_d = IDLE;
            count_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = '0;
         end else if (kp.key_code == KEY_ENTER) begin
            if (count_q == FULL) begin
               state_d = DONE;
               load_d  = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else if (kp.key_code == KEY_BKSP) begin
            if (count_q != '0) begin
               for (int i = 0; i < NUM_DIGITS - 1; i++) digit_d[i] = digit_q[i+1];
               digit_d[NUM_DIGITS-1] = '0;
               count_d = count_q - 1'b1;
               state_d = (count_q == 3'd1) ? IDLE : ENTRY;
            end
         end
         // Codes D-F fall through untouched; they still restart the timer.
      end else if (expire) begin
         state_d = IDLE;
         count_d = '0;
         to_d    = 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         load_q  <= load_d;
         err_q   <= err_d;
         to_q    <= to_d;
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      end
   end

   assign kp.digit4      = digit_q[3];
   assign kp.digit3      = digit_q[2];
   assign kp.digit2      = digit_q[1];
   assign kp.digit1      = digit_q[0];
   assign kp.count       = count_q;
   assign kp.load        = load_q;
   assign kp.entry_error = err_q;
   assign kp.timeout     = to_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
module tb_pin_entry_collector;

   localparam int TIMEOUT = 16;
   localparam int TW      = 5;

   logic clk;
   logic reset;

   pin_entry_collector_if bus ();

   pin_entry_collector #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        kv;
      logic [3:0]  kc;
      logic [15:0] dig;
      logic [2:0]  cnt;
      logic        ld;
      logic        er;
      logic        to;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [21:0] obs();
      return {bus.digit4, bus.digit3, bus.digit2, bus.digit1,
              bus.count, bus.load, bus.entry_error, bus.timeout};
   endfunction

   task automatic add(input logic kv, input logic [3:0] kc, input logic [15:0] dig,
                      input logic [2:0] cnt, input logic ld, input logic er, input logic to);
      vec_t v;
      v.kv = kv; v.kc = kc; v.dig = dig; v.cnt = cnt; v.ld = ld; v.er = er; v.to = to;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   function automatic logic [21:0] pack(input logic [15:0] dig, input logic [2:0] cnt,
                                        input logic ld, input logic er, input logic to);
      return {dig, cnt, ld, er, to};
   endfunction

   task automatic key(input logic [3:0] kc);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = kc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      reset = 1'b1;

      // kv kc     digits    cnt ld er to
      add(1, 4'h1, 16'h0001, 1, 0, 0, 0);
      add(1, 4'h2, 16'h0012, 2, 0, 0, 0);
      add(1, 4'h3, 16'h0123, 3, 0, 0, 0);
      add(1, 4'h4, 16'h1234, 4, 0, 0, 0);
      add(1, 4'hB, 16'h1234, 4, 1, 0, 0);
      add(0, 4'h0, 16'h0000, 0, 0, 0, 0);
      add(1, 4'h5, 16'h0005, 1, 0, 0, 0);
      add(1, 4'h6, 16'h0056, 2, 0, 0, 0);
      add(1, 4'hC, 16'h0005, 1, 0, 0, 0);
      add(1, 4'h7, 16'h0057, 2, 0, 0, 0);
      add(1, 4'hB, 16'h0057, 2, 0, 1, 0);
      add(0, 4'h0, 16'h0057, 2, 0, 0, 0);
      add(1, 4'hA, 16'h0000, 0, 0, 0, 0);
      add(1, 4'h1, 16'h0001, 1, 0, 0, 0);
      add(1, 4'h2, 16'h0012, 2, 0, 0, 0);
      add(1, 4'h3, 16'h0123, 3, 0, 0, 0);
      add(1, 4'h4, 16'h1234, 4, 0, 0, 0);
      add(1, 4'h9, 16'h1234, 4, 0, 0, 0);
      add(1, 4'hA, 16'h0000, 0, 0, 0, 0);
      add(1, 4'hE, 16'h0000, 0, 0, 0, 0);
      add(1, 4'hC, 16'h0000, 0, 0, 0, 0);
      add(1, 4'hB, 16'h0000, 0, 0, 1, 0);
      add(1, 4'h1, 16'h0001, 1, 0, 0, 0);
      add(1, 4'h2, 16'h0012, 2, 0, 0, 0);
      add(1, 4'h3, 16'h0123, 3, 0, 0, 0);
      add(1, 4'h4, 16'h1234, 4, 0, 0, 0);
      add(1, 4'hB, 16'h1234, 4, 1, 0, 0);
      add(1, 4'h3, 16'h0000, 0, 0, 0, 0);
      add(0, 4'h0, 16'h0000, 0, 0, 0, 0);

      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", obs(), 22'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.key_valid = vecs[i].kv;
         bus.key_code  = vecs[i].kc;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d key=%h/%h", i, vecs[i].kv, vecs[i].kc), obs(),
               pack(vecs[i].dig, vecs[i].cnt, vecs[i].ld, vecs[i].er, vecs[i].to));
      end

      // Timeout after 16 idle cycles.
      key(4'h8);
      check("to1_key", obs(), pack(16'h0008, 1, 0, 0, 0));
      for (int i = 1; i <= 15; i++) begin
         idle();
         check($sformatf("to1_idle%0d", i), obs(), pack(16'h0008, 1, 0, 0, 0));
      end
      idle();
      check("to1_expire", obs(), pack(16'h0000, 0, 0, 0, 1));
      idle();
      check("to1_after", obs(), pack(16'h0000, 0, 0, 0, 0));

      // A key at cycle 15 restarts the timer.
      key(4'h8);
      for (int i = 1; i <= 14; i++) idle();
      key(4'h9);
      check("to2_key15", obs(), pack(16'h0089, 2, 0, 0, 0));
      for (int i = 1; i <= 15; i++) begin
         idle();
         check($sformatf("to2_idle%0d", i), obs(), pack(16'h0089, 2, 0, 0, 0));
      end
      idle();
      check("to2_expire", obs(), pack(16'h0000, 0, 0, 0, 1));

      // Key coinciding with expiry wins.
      key(4'h8);
      for (int i = 1; i <= 15; i++) idle();
      key(4'h1);
      check("to3_coincide", obs(), pack(16'h0081, 2, 0, 0, 0));
      key(4'hA);
      check("to3_clear", obs(), pack(16'h0000, 0, 0, 0, 0));

      // Asynchronous reset mid-entry.
      key(4'h1);
      key(4'h2);
      check("rst_pre", obs(), pack(16'h0012, 2, 0, 0, 0));
      @(negedge clk);
      bus.key_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_async", obs(), 22'h0);
      @(negedge clk);
      reset = 1'b0;
      idle();
      check("rst_after", obs(), 22'h0);
      key(4'h7);
      check("rst_newkey", obs(), pack(16'h0007, 1, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
